nonce_result_collector: RTL and testbench

Tail-end consumer of the SHA-256 round pipeline: takes the state leaving the last delay stage, screens each final-round hash against a leading-zero difficulty target and queues winning nonces in a small FIFO. The host or control logic drains the FIFO over a valid/ready handshake. The block also keeps run statistics. It sits directly after the final delay stage and is the only point where pipeline results leave the hashing core.

---
 rtl/nonce_result_collector.sv | 141 ++++++++++++++
 tb/tb_nonce_result_collector.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_result_collector.sv
// Screens final-round hashes against a leading-zero target and queues winning
// nonces in a small FIFO drained over valid/ready; also keeps run statistics.
module nonce_result_collector #(
  parameter logic [7:0]  FINAL_ROUND = 8'd64,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset_en,
  input  logic         valid_in,
  input  logic [7:0]   round_in,
  input  logic [31:0]  nonce_in,
  input  logic [255:0] hash_in,
  input  logic [7:0]   target_zeros,
  input  logic         start,
  input  logic         stop,
  output logic         running,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [31:0]  result_nonce,
  output logic [31:0]  result_hash_hi,
  output logic [31:0]  hashes_checked,
  output logic [15:0]  found_count,
  output logic         overflow
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          cmp_push_q, cmp_push_d;
  logic [31:0]   cmp_nonce_q, cmp_nonce_d;
  logic [31:0]   cmp_hi_q, cmp_hi_d;
  logic [31:0]   hc_q, hc_d;
  logic [15:0]   fc_q, fc_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, remain;
  logic [31:0]   head_nonce_q, head_nonce_d;
  logic [31:0]   head_hi_q, head_hi_d;
  logic [63:0]   mem_q [FIFO_DEPTH];

  logic [255:0]  zmask;
  logic          match, qual, pop, push_req, full, push_acc, drop;

  // zmask has ones on exactly the top target_zeros bit positions
  assign zmask    = ~({256{1'b1}} >> target_zeros);
  assign match    = ((hash_in & zmask) == '0);
  assign qual     = valid_in && (round_in == FINAL_ROUND) && (state_q == S_RUN) && !start;
  assign pop      = result_valid && result_ready;
  assign push_req = cmp_push_q && !start;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign push_acc = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign remain   = count_q - CW'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (!start && stop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmp_push_d   = qual && match;
    cmp_nonce_d  = qual ? nonce_in : cmp_nonce_q;
    cmp_hi_d     = qual ? hash_in[255:224] : cmp_hi_q;
    hc_d         = (qual && hc_q != '1) ? hc_q + 32'd1 : hc_q;
    fc_d         = (push_req && fc_q != '1) ? fc_q + 16'd1 : fc_q;
    ovf_d        = ovf_q | drop;
    wr_ptr_d     = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = remain + CW'(push_acc);
    head_nonce_d = head_nonce_q;
    head_hi_d    = head_hi_q;
    // Head registers hold the last value once the FIFO runs empty
    if (remain == '0) begin
      if (push_acc) begin
        head_nonce_d = cmp_nonce_q;
        head_hi_d    = cmp_hi_q;
      end
    end else begin
      {head_nonce_d, head_hi_d} = mem_q[rd_ptr_d];
    end
    if (start) begin
      cmp_push_d   = 1'b0;
      hc_d         = '0;
      fc_d         = '0;
      ovf_d        = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_nonce_d = '0;
      head_hi_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_en) begin
      state_q      <= S_IDLE;
      cmp_push_q   <= 1'b0;
      cmp_nonce_q  <= '0;
      cmp_hi_q     <= '0;
      hc_q         <= '0;
      fc_q         <= '0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_nonce_q <= '0;
      head_hi_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmp_push_q   <= cmp_push_d;
      cmp_nonce_q  <= cmp_nonce_d;
      cmp_hi_q     <= cmp_hi_d;
      hc_q         <= hc_d;
      fc_q         <= fc_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_nonce_q <= head_nonce_d;
      head_hi_q    <= head_hi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_en && push_acc) mem_q[wr_ptr_q] <= {cmp_nonce_q, cmp_hi_q};
  end

  assign running        = (state_q == S_RUN);
  assign result_valid   = (count_q != '0);
  assign result_nonce   = head_nonce_q;
  assign result_hash_hi = head_hi_q;
  assign hashes_checked = hc_q;
  assign found_count    = fc_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_nonce_result_collector.sv
// Randomized scoreboard bench: the driver records expected FIFO candidates, a
// negedge monitor models the result queue and checks every pop.
module tb_nonce_result_collector;
  localparam logic [7:0] FR = 8'd64;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset_en = 1'b0;
  logic         valid_in = 1'b0;
  logic [7:0]   round_in = '0;
  logic [31:0]  nonce_in = '0;
  logic [255:0] hash_in = '0;
  logic [7:0]   target_zeros = '0;
  logic         start = 1'b0, stop = 1'b0;
  logic         running, result_valid, result_ready = 1'b0;
  logic [31:0]  result_nonce, result_hash_hi, hashes_checked;
  logic [15:0]  found_count;
  logic         overflow;

  nonce_result_collector #(.FINAL_ROUND(FR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_en(reset_en), .valid_in(valid_in), .round_in(round_in),
    .nonce_in(nonce_in), .hash_in(hash_in), .target_zeros(target_zeros),
    .start(start), .stop(stop), .running(running), .result_valid(result_valid),
    .result_ready(result_ready), .result_nonce(result_nonce),
    .result_hash_hi(result_hash_hi), .hashes_checked(hashes_checked),
    .found_count(found_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] n; logic [31:0] hi; int e; } cand_t;
  cand_t cand_q[$];
  cand_t mq[$];
  int    edge_cnt = 0;
  int    checks = 0, errors = 0, pop_cnt = 0;
  logic  mrun = 1'b0, ovf_exp = 1'b0;
  logic [31:0] hc_exp = '0;
  logic [15:0] fc_exp = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clz(input logic [255:0] h);
    int n = 0;
    for (int i = 255; i >= 0; i--) begin
      if (h[i]) return n;
      n++;
    end
    return n;
  endfunction

  // Queue model: pop first, then accept the push due at the coming edge
  always @(negedge clk) begin
    if (edge_cnt >= 1) begin
      chk("valid", result_valid, (mq.size() != 0));
      chk("overflow", overflow, ovf_exp);
      if (result_valid && result_ready) begin
        if (mq.size() == 0) chk("pop_empty", 1'b1, 1'b0);
        else begin
          chk("head_nonce", result_nonce, mq[0].n);
          chk("head_hi", result_hash_hi, mq[0].hi);
          void'(mq.pop_front());
        end
        pop_cnt++;
      end
      if (!reset_en || start) begin
        mq.delete();
        ovf_exp = 1'b0;
        while (cand_q.size() != 0 && cand_q[0].e <= edge_cnt + 1) void'(cand_q.pop_front());
      end else begin
        while (cand_q.size() != 0 && cand_q[0].e <= edge_cnt + 1) begin
          if (mq.size() < DEPTH) mq.push_back(cand_q[0]);
          else ovf_exp = 1'b1;
          void'(cand_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic v, input logic [7:0] rnd, input logic [31:0] n,
                      input logic [255:0] h, input logic [7:0] tz);
    cand_t c;
    valid_in = v; round_in = rnd; nonce_in = n; hash_in = h; target_zeros = tz;
    if (v && rnd == FR && mrun) begin
      if (hc_exp != '1) hc_exp++;
      if (clz(h) >= int'(tz)) begin
        if (fc_exp != '1) fc_exp++;
        c.n = n; c.hi = h[255:224]; c.e = edge_cnt + 2;
        cand_q.push_back(c);
      end
    end
    cyc();
    valid_in = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; mrun = 1'b1; hc_exp = '0; fc_exp = '0;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; mrun = 1'b0;
    cyc();
    stop = 1'b0;
  endtask

  task automatic do_reset();
    reset_en = 1'b0; mrun = 1'b0; hc_exp = '0; fc_exp = '0;
    cyc();
    reset_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_cnt(input string name);
    chk({name, "_hc"}, hashes_checked, hc_exp);
    chk({name, "_fc"}, found_count, fc_exp);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_run"}, running, 1'b0);
    chk({name, "_valid"}, result_valid, 1'b0);
    chk({name, "_nonce"}, result_nonce, 32'd0);
    chk({name, "_hi"}, result_hash_hi, 32'd0);
    chk({name, "_hc"}, hashes_checked, 32'd0);
    chk({name, "_fc"}, found_count, 16'd0);
    chk({name, "_ovf"}, overflow, 1'b0);
  endtask

  task automatic drain();
    int k = 0;
    result_ready = 1'b1;
    while ((mq.size() != 0 || cand_q.size() != 0) && k < 50) begin cyc(); k++; end
    if (k >= 50) chk("drain_timeout", 1'b1, 1'b0);
    idle(2);
  endtask

  function automatic logic [255:0] rhash();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [255:0] h1;
    h1 = {32'h0000_0001, rhash() >> 32};
    idle(2);
    chk_zero("reset");
    reset_en = 1'b1;
    cyc();
    do_start();
    chk("start_run", running, 1'b1);

    // Three matches, target 24, consumer always ready
    result_ready = 1'b1;
    for (int i = 5; i <= 7; i++) beat(1'b1, FR, i, h1, 8'd24);
    idle(4);
    chk_cnt("tp1");

    // Target 32 against hash_hi 1: no match
    do_start();
    beat(1'b1, FR, 32'd9, h1, 8'd32);
    idle(4);
    chk_cnt("tp2");

    // Non-qualifying beats, then IDLE beats
    beat(1'b1, FR - 8'd1, 32'd10, '0, 8'd0);
    beat(1'b0, FR, 32'd11, '0, 8'd0);
    idle(3);
    chk_cnt("noqual");
    beat(1'b1, FR, 32'd12, '0, 8'd0);
    do_stop();
    chk("stop_run", running, 1'b0);
    beat(1'b1, FR, 32'd13, '0, 8'd0);
    idle(3);
    chk_cnt("idle_beat");
    drain();

    // Six matches into a stalled FIFO
    do_start();
    result_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat(1'b1, FR, 32'h100 + i, rhash() >> 8, 8'd8);
    idle(3);
    chk_cnt("tp3");
    chk("tp3_ovf", overflow, 1'b1);
    drain();

    // Full FIFO with push and pop in the same cycle
    do_start();
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b1, FR, 32'h200 + i, '0, 8'd0);
    idle(3);
    pop_cnt = 0;
    beat(1'b1, FR, 32'h2FF, '0, 8'd0);
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;
    idle(2);
    chk("tp4_ovf", overflow, 1'b0);
    chk("tp4_pops", pop_cnt, 1);
    drain();
    chk("tp4_total", pop_cnt, 5);

    // Target boundaries: 0 matches all, 255 needs hash[255:1]==0
    do_start();
    result_ready = 1'b1;
    beat(1'b1, FR, 32'h300, rhash() | (256'd1 << 255), 8'd0);
    beat(1'b1, FR, 32'h301, 256'd1, 8'd255);
    beat(1'b1, FR, 32'h302, 256'd2, 8'd255);
    beat(1'b1, FR, 32'h303, 256'd1, 8'd0);
    do_stop();
    idle(3);
    chk_cnt("bound");
    drain();

    // Randomized traffic
    do_start();
    for (int i = 0; i < 300; i++) begin
      logic [7:0] tz;
      result_ready = ($urandom_range(0, 2) != 0);
      tz = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) do_start();
      else if ($urandom_range(0, 39) == 0) do_stop();
      else if ($urandom_range(0, 39) == 0) do_start();
      else beat($urandom_range(0, 3) != 0, ($urandom_range(0, 5) == 0) ? FR - 8'd1 : FR,
                $urandom(), rhash() >> $urandom_range(0, 14), tz);
    end
    idle(3);
    chk_cnt("rand");
    drain();

    // Reset mid-run with two entries queued
    do_start();
    result_ready = 1'b0;
    beat(1'b1, FR, 32'h400, '0, 8'd0);
    beat(1'b1, FR, 32'h401, '0, 8'd0);
    idle(2);
    do_reset();
    chk_zero("midreset");
    idle(1);

    // Restart while running empties the FIFO
    do_start();
    beat(1'b1, FR, 32'h500, '0, 8'd0);
    beat(1'b1, FR, 32'h501, '0, 8'd0);
    idle(2);
    chk("pre_restart_valid", result_valid, 1'b1);
    do_start();
    chk("restart_valid", result_valid, 1'b0);
    chk("restart_run", running, 1'b1);
    chk_cnt("restart");
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
